ahb_sram_ctrl: RTL and testbench

- AHB-Lite slave that acts as the initiator for a 32-bit bank built from four 8-bit negedge-clocked single-port SRAM macros (CEN/WEN/A/D/Q/OEN interface, one macro per byte lane).
- Turns AHB address/data phases into single SRAM accesses, including per-lane byte/halfword strobes.
- Zero wait states for legal transfers; two-cycle ERROR response for illegal ones.
- Sits behind the AHB decoder/mux as the on-chip RAM slave.

---
 rtl/ahb_sram_ctrl_pkg.sv | 42 ++++
 rtl/ahb_sram_ctrl_if.sv | 33 +++
 rtl/ahb_sram_lane_dec.sv | 50 +++++
 rtl/ahb_sram_ctrl.sv | 141 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ahb_sram_ctrl_pkg
// Shared definitions for the AHB-Lite on-chip SRAM slave:
//   - HTRANS / HSIZE / HRESP encodings
//   - controller FSM state type
//   - trans_active(): address-phase transfer-type qualifier
// ---------------------------------------------------------------------------
package ahb_sram_ctrl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ERR1   = 2'b10,
    ST_ERR2   = 2'b11
  } state_e;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic trans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_NONSEQ: act = 1'b1;
      HTRANS_SEQ:    act = 1'b1;
      HTRANS_IDLE:   act = 1'b0;
      HTRANS_BUSY:   act = 1'b0;
      default:       act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_ctrl_if
// AHB-Lite slave-side bus bundle for the SRAM controller.
//   master modport : drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY,
//                    observes HREADYOUT/HRESP/HRDATA
//   slave modport  : the mirror image (used by ahb_sram_ctrl)
// HREADY is the bus-wide ready from the response mux; it sits on the
// master side because it is an input to every slave.
// ---------------------------------------------------------------------------
interface ahb_sram_ctrl_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_sram_lane_dec.sv
// ---------------------------------------------------------------------------
// ahb_sram_lane_dec
// Combinational byte-lane decoder for a 32-bit little-endian bank.
//   hsize_i     : HSIZE of the address phase
//   haddr_i     : HADDR[1:0] of the address phase
//   lane_mask_o : active-high lane enables (bit i = byte [8i+7:8i])
//   illegal_o   : size > word, or size/alignment mismatch
// The mask is forced to zero for illegal transfers so nothing downstream
// can strobe a lane by accident.
// ---------------------------------------------------------------------------
module ahb_sram_lane_dec
  import ahb_sram_ctrl_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] haddr_i,
  output logic [3:0] lane_mask_o,
  output logic       illegal_o
);

  // Size/alignment decode into lane mask and legality.
  always_comb begin
    lane_mask_o = 4'b0000;
    illegal_o   = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: begin
        lane_mask_o = 4'b0001 << haddr_i;
      end
      HSIZE_HALF: begin
        if (haddr_i[0]) begin
          illegal_o = 1'b1;
        end else if (haddr_i[1]) begin
          lane_mask_o = 4'b1100;
        end else begin
          lane_mask_o = 4'b0011;
        end
      end
      HSIZE_WORD: begin
        if (haddr_i != 2'b00) begin
          illegal_o = 1'b1;
        end else begin
          lane_mask_o = 4'b1111;
        end
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_sram_ctrl
// AHB-Lite slave driving a 32-bit bank of four 8-bit negedge-clocked
// single-port SRAM macros (one per byte lane). Zero wait states for legal
// transfers, two-cycle ERROR response for illegal size/alignment.
//   CLK, RST   : clock (shared with the macros), synchronous active-high reset
//   ahb        : AHB-Lite slave bundle (ahb_sram_ctrl_if.slave)
//   SRAM_CEN   : per-lane chip enable, active-low, registered
//   SRAM_WEN   : shared write enable, active-low, registered
//   SRAM_A     : shared word address, registered
//   SRAM_D     : write data, straight from HWDATA
//   SRAM_Q     : concatenated lane read data, returned as HRDATA
//   SRAM_OEN   : output enable, tied low
// Timing: strobes are registered at the address-phase posedge, the macros
// act on the negedge inside the data phase, so write data (combinational
// from HWDATA) and read data (SRAM_Q to HRDATA) both settle within the
// single data-phase cycle.
// ---------------------------------------------------------------------------
module ahb_sram_ctrl
  import ahb_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int WORD_DEPTH = 8192,
  parameter int BITS       = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  ahb_sram_ctrl_if.slave        ahb,
  output logic [3:0]            SRAM_CEN,
  output logic                  SRAM_WEN,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [31:0]           SRAM_D,
  input  logic [31:0]           SRAM_Q,
  output logic                  SRAM_OEN
);

  // The bank is four byte-wide macros fully covering the word address space.
  if ((WORD_DEPTH != (1 << ADDR_WIDTH)) || (BITS != 8)) begin : g_param_check
    $error("ahb_sram_ctrl: WORD_DEPTH must equal 2**ADDR_WIDTH and BITS must be 8");
  end

  state_e                state_q;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic [3:0]            sram_cen_q;
  logic                  sram_wen_q;
  logic [ADDR_WIDTH-1:0] sram_a_q;

  logic                  addr_sample;
  logic [3:0]            dec_mask;
  logic                  dec_illegal;
  logic [3:0]            lane_mask_d;

  // Upper address bits alias onto the bank; range checking is the decoder's job.
  logic unused_haddr;
  assign unused_haddr = ^ahb.HADDR[31:ADDR_WIDTH+2];

  ahb_sram_lane_dec u_lane_dec (
    .hsize_i     (ahb.HSIZE),
    .haddr_i     (ahb.HADDR[1:0]),
    .lane_mask_o (dec_mask),
    .illegal_o   (dec_illegal)
  );

  // A transfer is taken only when we are selected, the bus is ready and
  // the transfer type is NONSEQ/SEQ.
  always_comb begin
    addr_sample = ahb.HSEL & ahb.HREADY & trans_active(ahb.HTRANS);
  end

  // Reads fetch the whole word regardless of size; writes touch only the
  // addressed lanes.
  always_comb begin
    if (ahb.HWRITE) begin
      lane_mask_d = dec_mask;
    end else begin
      lane_mask_d = 4'b1111;
    end
  end

  // Controller FSM with registered bus response and SRAM strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      sram_cen_q  <= 4'hF;
      sram_wen_q  <= 1'b1;
      sram_a_q    <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_q)
        // First error cycle: stall the master so it can cancel its next
        // transfer; HREADY is low here so no address phase can be taken.
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
          sram_cen_q  <= 4'hF;
        end
        // ERR2 accepts a new address phase just like IDLE/ACCESS.
        ST_IDLE, ST_ACCESS, ST_ERR2: begin
          if (addr_sample && dec_illegal) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
            sram_cen_q  <= 4'hF;
          end else if (addr_sample) begin
            state_q     <= ST_ACCESS;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            sram_cen_q  <= ~lane_mask_d;
            sram_wen_q  <= ~ahb.HWRITE;
            sram_a_q    <= ahb.HADDR[ADDR_WIDTH+1:2];
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            sram_cen_q  <= 4'hF;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          sram_cen_q  <= 4'hF;
        end
      endcase
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = SRAM_Q;

  assign SRAM_CEN = sram_cen_q;
  assign SRAM_WEN = sram_wen_q;
  assign SRAM_A   = sram_a_q;
  assign SRAM_D   = ahb.HWDATA;
  assign SRAM_OEN = 1'b0;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_ctrl
// Directed bench for ahb_sram_ctrl. Each step drives one address phase
// (plus the write data of the previous one), checks the current data-phase
// cycle against the scoreboard entry pushed one step earlier, then pushes
// the expectation for the next cycle. Four behavioural negedge byte macros
// stand in for the SRAM bank.
// ---------------------------------------------------------------------------
module tb_ahb_sram_ctrl;

  localparam int K_IDLE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ERR1 = 3;
  localparam int K_ERR2 = 4;
  localparam int K_RST  = 5;

  typedef struct {
    int          kind;
    logic [3:0]  cen;
    logic [12:0] a;
    logic        wen;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  SRAM_CEN;
  logic        SRAM_WEN;
  logic [12:0] SRAM_A;
  logic [31:0] SRAM_D;
  logic [31:0] SRAM_Q;
  logic        SRAM_OEN;

  ahb_sram_ctrl_if bus ();

  ahb_sram_ctrl #(
    .ADDR_WIDTH (13),
    .WORD_DEPTH (8192),
    .BITS       (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ahb      (bus),
    .SRAM_CEN (SRAM_CEN),
    .SRAM_WEN (SRAM_WEN),
    .SRAM_A   (SRAM_A),
    .SRAM_D   (SRAM_D),
    .SRAM_Q   (SRAM_Q),
    .SRAM_OEN (SRAM_OEN)
  );

  always #5 CLK = ~CLK;

  // Behavioural macros: act on negedge when enabled, Q holds otherwise.
  logic [7:0]  mem [0:3][0:8191];
  logic [31:0] sram_q_r = 32'h0;
  assign SRAM_Q = sram_q_r;

  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (SRAM_CEN[i] == 1'b0) begin
        if (SRAM_WEN == 1'b0) begin
          mem[i][SRAM_A] <= SRAM_D[8*i +: 8];
        end else begin
          sram_q_r[8*i +: 8] <= mem[i][SRAM_A];
        end
      end
    end
  end

  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pend_wdata = 32'h0;
  logic        nxt_err2 = 1'b0;

  function automatic logic [3:0] ref_lanes(input logic [2:0] size, input logic [1:0] a);
    if (size == 3'd0) return 4'b0001 << a;
    if (size == 3'd1) return 4'b0011 << {a[1], 1'b0};
    return 4'b1111;
  endfunction

  function automatic logic ref_illegal(input logic [2:0] size, input logic [1:0] a);
    return (size > 3'd2) || ((size == 3'd1) && a[0]) || ((size == 3'd2) && (a != 2'b00));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input exp_t e);
    logic rdy_e;
    logic resp_e;
    rdy_e  = (e.kind == K_ERR1) ? 1'b0 : 1'b1;
    resp_e = ((e.kind == K_ERR1) || (e.kind == K_ERR2)) ? 1'b1 : 1'b0;
    chk("hreadyout", {31'd0, bus.HREADYOUT}, {31'd0, rdy_e});
    chk("hresp", {31'd0, bus.HRESP}, {31'd0, resp_e});
    chk("sram_cen", {28'd0, SRAM_CEN}, {28'd0, e.cen});
    if ((e.kind == K_WR) || (e.kind == K_RD) || (e.kind == K_RST)) begin
      chk("sram_a", {19'd0, SRAM_A}, {19'd0, e.a});
      chk("sram_wen", {31'd0, SRAM_WEN}, {31'd0, e.wen});
    end
    if (e.kind == K_WR) chk("sram_d", SRAM_D, e.data);
    if (e.kind == K_RD) chk("hrdata", bus.HRDATA, e.data);
  endtask

  // Called at posedge+1: drive, check at posedge+7 (after the negedge), push next.
  task automatic step(input logic rst, input logic sel, input logic [1:0] trans,
                      input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] data, input logic rdy);
    exp_t        e;
    exp_t        n;
    logic [3:0]  m;
    logic [31:0] w;
    int          widx;
    RST        = rst;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
    bus.HREADY = rdy;
    bus.HWDATA = pend_wdata;
    #6;
    chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_cycle(e);
    end
    n.kind = K_IDLE;
    n.cen  = 4'hF;
    n.a    = 13'd0;
    n.wen  = 1'b1;
    n.data = 32'h0;
    if (rst) begin
      n.kind   = K_RST;
      nxt_err2 = 1'b0;
    end else if (nxt_err2) begin
      n.kind   = K_ERR2;
      nxt_err2 = 1'b0;
    end else if (sel && rdy && trans[1]) begin
      if (ref_illegal(size, addr[1:0])) begin
        n.kind   = K_ERR1;
        nxt_err2 = 1'b1;
      end else begin
        widx = int'(addr[14:2]);
        n.a  = addr[14:2];
        if (wr) begin
          m      = ref_lanes(size, addr[1:0]);
          n.kind = K_WR;
          n.wen  = 1'b0;
          n.cen  = ~m;
          n.data = data;
          w = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
          for (int i = 0; i < 4; i++) begin
            if (m[i]) w[8*i +: 8] = data[8*i +: 8];
          end
          ref_mem[widx] = w;
        end else begin
          n.kind = K_RD;
          n.cen  = 4'h0;
          n.data = ref_mem[widx];
        end
      end
    end
    sb.push_back(n);
    pend_wdata = data;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_t(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 2'b10, 1'b1, s, a, d, 1'b1);
  endtask

  task automatic rd_t(input logic [2:0] s, input logic [31:0] a);
    step(1'b0, 1'b1, 2'b10, 1'b0, s, a, 32'h0, 1'b1);
  endtask

  task automatic idle_t();
    step(1'b0, 1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
  endtask

  // Cycle while we stall with ERROR: bus HREADY is low, master idles.
  task automatic err_t();
    step(1'b0, 1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    exp_t r;
    bus.HSEL   = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd0;
    bus.HWDATA = 32'h0;
    bus.HREADY = 1'b1;
    RST        = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    r.kind = K_RST; r.cen = 4'hF; r.a = 13'd0; r.wen = 1'b1; r.data = 32'h0;
    sb.push_back(r);
    chk("sram_oen", {31'd0, SRAM_OEN}, 32'd0);

    // Word write then word read at 0x10.
    wr_t(3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    rd_t(3'd2, 32'h0000_0010);
    idle_t();

    // Byte write into lane 3 over a known word.
    wr_t(3'd2, 32'h0000_0010, 32'h1122_3344);
    wr_t(3'd0, 32'h0000_0013, 32'hAA00_0000);
    rd_t(3'd2, 32'h0000_0010);
    idle_t();

    // Halfword write to the upper half, read back as half and as word.
    wr_t(3'd2, 32'h0000_0020, 32'h5566_7788);
    wr_t(3'd1, 32'h0000_0022, 32'hBEEF_0000);
    rd_t(3'd1, 32'h0000_0022);
    rd_t(3'd2, 32'h0000_0020);
    idle_t();

    // Back-to-back write then read of the same word; aliased address too.
    wr_t(3'd2, 32'h0000_0040, 32'h0000_0001);
    rd_t(3'd2, 32'h0000_0040);
    rd_t(3'd0, 32'h0000_0041);
    rd_t(3'd2, 32'h8000_0040);
    idle_t();

    // Misaligned word: two-cycle ERROR, then a read taken during ERR2.
    wr_t(3'd2, 32'h0000_0002, 32'h1234_5678);
    err_t();
    rd_t(3'd2, 32'h0000_0010);
    // Oversize transfer, then plain idle in ERR2, then a legal read.
    rd_t(3'd3, 32'h0000_0040);
    err_t();
    idle_t();
    rd_t(3'd2, 32'h0000_0040);
    // Odd halfword.
    wr_t(3'd1, 32'h0000_0021, 32'hFFFF_FFFF);
    err_t();
    idle_t();
    rd_t(3'd2, 32'h0000_0020);

    // Reset asserted in the first ERROR cycle aborts the response.
    wr_t(3'd2, 32'h0000_0006, 32'h0BAD_0BAD);
    step(1'b1, 1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    idle_t();

    // Non-transfers: BUSY, unselected, and HREADY low from another slave.
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'd2, 32'h0000_0010, 32'h0, 1'b1);
    step(1'b0, 1'b0, 2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'h0, 1'b1);
    step(1'b0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'h0, 1'b0);
    step(1'b0, 1'b1, 2'b11, 1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b0);
    idle_t();
    rd_t(3'd2, 32'h0000_0010);
    idle_t();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
